// File: rtl/seven_segment_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scanner_if
// Brief    : Display-data and pin-side signals of the seven-segment scanner.
// Revision : 1.0 - initial release
// ============================================================================
interface seven_segment_scanner_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink;
    logic                    load;
    logic [6:0]              seg;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    frame_tick;

    modport master (
        output digits, dp_in, blank, blink, load,
        input  seg, dp_out, anode, frame_tick
    );

    modport slave (
        input  digits, dp_in, blank, blink, load,
        output seg, dp_out, anode, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scanner
// Brief    : Multiplexed N-digit common-anode display driver with frame-synced
//            loading, anti-ghosting guard time and blinking.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4,
    parameter int BLINK_DIV   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    seven_segment_scanner_if.slave bus
);
    localparam int c_pcnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_idx_w  = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;
    localparam int c_fcnt_w = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;

    localparam logic [c_pcnt_w-1:0] c_pcnt_max = c_pcnt_w'(REFRESH_DIV - 1);
    localparam logic [c_pcnt_w-1:0] c_guard    = c_pcnt_w'(GUARD);
    localparam logic [c_idx_w-1:0]  c_idx_max  = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_fcnt_w-1:0] c_fcnt_max = c_fcnt_w'(BLINK_DIV - 1);

    logic [c_pcnt_w-1:0]     r_pcnt;
    logic [c_idx_w-1:0]      r_idx;
    logic [c_fcnt_w-1:0]     r_fcnt;
    logic                    r_bphase;
    logic                    r_pending;

    logic [4*NUM_DIGITS-1:0] r_stg_digits;
    logic [NUM_DIGITS-1:0]   r_stg_dp;
    logic [NUM_DIGITS-1:0]   r_stg_blank;
    logic [NUM_DIGITS-1:0]   r_stg_blink;

    logic [4*NUM_DIGITS-1:0] r_act_digits;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic [NUM_DIGITS-1:0]   r_act_blink;

    logic [6:0]              r_seg;
    logic                    r_dp_out;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic                    r_frame_tick;

    logic                    w_pwrap;
    logic                    w_boundary;
    logic                    w_guard;
    logic                    w_dark;
    logic [3:0]              w_code;
    logic [6:0]              w_glyph;
    logic [NUM_DIGITS-1:0]   w_anode;

    always_comb begin
        w_pwrap    = (r_pcnt == c_pcnt_max);
        w_boundary = w_pwrap && (r_idx == c_idx_max);
        w_guard    = (r_pcnt < c_guard);
        w_code     = r_act_digits[{r_idx, 2'b00} +: 4];
        w_dark     = r_act_blank[r_idx] | (r_act_blink[r_idx] & r_bphase);
        w_anode    = '1;
        w_anode[r_idx] = 1'b0;
        // Segment order is {a,b,c,d,e,f,g}, 0 = lit.
        case (w_code)
            4'h0:    w_glyph = 7'b0000001;
            4'h1:    w_glyph = 7'b1001111;
            4'h2:    w_glyph = 7'b0010010;
            4'h3:    w_glyph = 7'b0000110;
            4'h4:    w_glyph = 7'b1001100;
            4'h5:    w_glyph = 7'b0100100;
            4'h6:    w_glyph = 7'b0100000;
            4'h7:    w_glyph = 7'b0001111;
            4'h8:    w_glyph = 7'b0000000;
            4'h9:    w_glyph = 7'b0000100;
            4'hA:    w_glyph = 7'b1111110;
            4'hB:    w_glyph = 7'b0111000;
            4'hC:    w_glyph = 7'b0110001;
            4'hD:    w_glyph = 7'b1101010;
            4'hE:    w_glyph = 7'b1000010;
            default: w_glyph = 7'b1000001;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt       <= '0;
            r_idx        <= '0;
            r_fcnt       <= '0;
            r_bphase     <= 1'b0;
            r_pending    <= 1'b0;
            r_stg_digits <= '0;
            r_stg_dp     <= '0;
            r_stg_blank  <= '1;
            r_stg_blink  <= '0;
            r_act_digits <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '1;
            r_act_blink  <= '0;
            r_seg        <= 7'h7F;
            r_dp_out     <= 1'b1;
            r_anode      <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_pcnt <= w_pwrap ? '0 : r_pcnt + 1'b1;
            if (w_pwrap) begin
                r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
            end

            if (bus.load) begin
                r_stg_digits <= bus.digits;
                r_stg_dp     <= bus.dp_in;
                r_stg_blank  <= bus.blank;
                r_stg_blink  <= bus.blink;
            end

            // Active set only moves at a frame boundary; a coincident load bypasses staging.
            if (w_boundary) begin
                if (bus.load) begin
                    r_act_digits <= bus.digits;
                    r_act_dp     <= bus.dp_in;
                    r_act_blank  <= bus.blank;
                    r_act_blink  <= bus.blink;
                end else if (r_pending) begin
                    r_act_digits <= r_stg_digits;
                    r_act_dp     <= r_stg_dp;
                    r_act_blank  <= r_stg_blank;
                    r_act_blink  <= r_stg_blink;
                end
                r_pending <= 1'b0;
                r_fcnt    <= (r_fcnt == c_fcnt_max) ? '0 : r_fcnt + 1'b1;
                if (r_fcnt == c_fcnt_max) begin
                    r_bphase <= ~r_bphase;
                end
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end

            r_frame_tick <= w_boundary;

            if (w_guard) begin
                r_anode  <= '1;
                r_seg    <= 7'h7F;
                r_dp_out <= 1'b1;
            end else begin
                r_anode  <= w_anode;
                r_seg    <= w_dark ? 7'h7F : w_glyph;
                r_dp_out <= w_dark | ~r_act_dp[r_idx];
            end
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dp_out     = r_dp_out;
    assign bus.anode      = r_anode;
    assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_scanner
// Brief    : Randomized scoreboard bench for seven_segment_scanner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scanner;
    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int GD    = 2;
    localparam int BD    = 2;
    localparam int FRAME = ND * RD;

    localparam logic [6:0] GTAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b1111110, 7'b0111000,
        7'b0110001, 7'b1101010, 7'b1000010, 7'b1000001
    };

    logic clk = 1'b0;
    logic rst = 1'b1;

    seven_segment_scanner_if #(.NUM_DIGITS(ND)) bus ();

    seven_segment_scanner #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .GUARD      (GD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  p;
        logic [4*ND-1:0]     digits;
        logic [ND-1:0]       dp;
        logic [ND-1:0]       blank;
        logic [ND-1:0]       blink;
    } load_t;

    typedef struct packed {
        logic [ND-1:0] anode;
        logic [6:0]    seg;
        logic          dp;
        logic          tick;
    } obs_t;

    load_t log_q [$];
    obs_t  exp_q [$];
    int    ncyc    = 0;
    bit    started = 1'b0;
    int    total   = 0;
    int    bad     = 0;

    // Expected pins after the n-th clock edge since reset release (n=0: reset edge).
    // The display during frame f shows the last load issued before frame f began.
    function automatic obs_t model(input int n);
        obs_t  o;
        load_t a;
        int    p, pc, idx, f;
        bit    bph, dark;
        o.anode = '1;
        o.seg   = 7'h7F;
        o.dp    = 1'b1;
        o.tick  = 1'b0;
        if (n == 0) return o;
        o.tick = (n % FRAME == 0);
        p   = n - 1;
        pc  = p % RD;
        idx = (p / RD) % ND;
        f   = p / FRAME;
        if (pc < GD) return o;
        a.p      = 0;
        a.digits = '0;
        a.dp     = '0;
        a.blank  = '1;
        a.blink  = '0;
        foreach (log_q[i]) begin
            if (log_q[i].p <= f * FRAME - 1) a = log_q[i];
        end
        bph  = ((f / BD) % 2) == 1;
        dark = a.blank[idx] || (a.blink[idx] && bph);
        o.anode[idx] = 1'b0;
        if (!dark) begin
            o.seg = GTAB[a.digits[idx*4 +: 4]];
            o.dp  = ~a.dp[idx];
        end
        return o;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            ncyc    = 0;
            log_q.delete();
            exp_q.push_back(model(0));
        end else if (started) begin
            ncyc++;
            exp_q.push_back(model(ncyc));
        end
    end

    obs_t mon_e, mon_a;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a.anode = bus.anode;
            mon_a.seg   = bus.seg;
            mon_a.dp    = bus.dp_out;
            mon_a.tick  = bus.frame_tick;
            total++;
            if (mon_a !== mon_e) begin
                bad++;
                $display("FAIL pins n=%0d anode/seg/dp/tick got %b/%b/%b/%b want %b/%b/%b/%b",
                         ncyc, mon_a.anode, mon_a.seg, mon_a.dp, mon_a.tick,
                         mon_e.anode, mon_e.seg, mon_e.dp, mon_e.tick);
            end
            total++;
            if ($countones(~bus.anode) > 1) begin
                bad++;
                $display("FAIL onehot n=%0d anode got %b want at most one low", ncyc, bus.anode);
            end
        end
    end

    task automatic tick_n(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_load(input logic [4*ND-1:0] d, input logic [ND-1:0] dpv,
                           input logic [ND-1:0] bl, input logic [ND-1:0] bk);
        load_t e;
        bus.digits = d;
        bus.dp_in  = dpv;
        bus.blank  = bl;
        bus.blink  = bk;
        bus.load   = 1'b1;
        e.p = ncyc; e.digits = d; e.dp = dpv; e.blank = bl; e.blink = bk;
        log_q.push_back(e);
        @(negedge clk);
        bus.load   = 1'b0;
        bus.digits = 16'($urandom);
        bus.dp_in  = 4'($urandom);
        bus.blank  = 4'($urandom);
        bus.blink  = 4'($urandom);
    endtask

    task automatic wait_pos(input int pos);
        while (ncyc % FRAME != pos) @(negedge clk);
    endtask

    initial begin
        bus.load   = 1'b0;
        bus.digits = '0;
        bus.dp_in  = '0;
        bus.blank  = '0;
        bus.blink  = '0;
        rst = 1'b1;
        tick_n(3);
        rst = 1'b0;
        tick_n(100);

        do_load(16'h3210, 4'b0100, 4'b0000, 4'b0000);
        tick_n(80);

        wait_pos(10);
        do_load(16'hFEDC, 4'($urandom), 4'b0000, 4'b0000);
        tick_n(70);

        wait_pos(FRAME - 1);
        do_load(16'h8888, 4'b0000, 4'b0000, 4'b0000);
        tick_n(70);

        do_load(16'h5A37, 4'b1010, 4'b0000, 4'b0001);
        tick_n(8 * FRAME);

        for (int i = 0; i < 25; i++) begin
            do_load(16'($urandom), 4'($urandom), 4'($urandom & $urandom), 4'($urandom));
            tick_n($urandom_range(1, 90));
        end

        // Pending load in digit-2 slot, then reset before it can transfer.
        wait_pos(2 * RD + 2);
        do_load(16'h1234, 4'b1111, 4'b0000, 4'b0000);
        tick_n(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick_n(100);

        for (int i = 0; i < 10; i++) begin
            do_load(16'($urandom), 4'($urandom), 4'($urandom & $urandom), 4'($urandom));
        end
        tick_n(3 * FRAME);

        for (int i = 0; i < 12; i++) begin
            wait_pos(($urandom_range(0, 1) == 1) ? FRAME - 1 : int'($urandom_range(0, FRAME - 2)));
            do_load(16'($urandom), 4'($urandom), 4'($urandom & $urandom), 4'($urandom));
            tick_n($urandom_range(1, 40));
        end
        tick_n(2 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog n=%0d got no finish want finish", ncyc);
        $fatal(1);
    end
endmodule
`default_nettype wire
